// File: rtl/gray_window_buffer.sv
// 3x3 sliding-window builder for a raster pixel stream: two line buffers plus a 3-column shift window.
// Optional frame_done_o / frame_count_o outputs are enabled by defining GRAY_WINDOW_FRAME_DONE_EN.
module gray_window_buffer #(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_WIDTH   = 32,
   parameter int IMG_HEIGHT  = 32
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic [PIXEL_WIDTH-1:0]          px_i,
   input  logic                            px_valid_i,
   input  logic                            frame_restart_i,
   output logic [9*PIXEL_WIDTH-1:0]        window_o,
   output logic                            window_valid_o,
   output logic [$clog2(IMG_HEIGHT)-1:0]   center_row_o,
   output logic [$clog2(IMG_WIDTH)-1:0]    center_col_o
`ifdef GRAY_WINDOW_FRAME_DONE_EN
   ,
   output logic                            frame_done_o,
   output logic [7:0]                      frame_count_o
`endif
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

   logic [CW-1:0]            col;
   logic [RW-1:0]            row;
   logic [CW-1:0]            col_cur;
   logic [RW-1:0]            row_cur;
   logic [PIXEL_WIDTH-1:0]   lb_a [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0]   lb_b [IMG_WIDTH];
   logic [PIXEL_WIDTH-1:0]   lb_a_rd;
   logic [PIXEL_WIDTH-1:0]   lb_b_rd;
   logic [PIXEL_WIDTH-1:0]   win_p0 [9];
   logic [PIXEL_WIDTH-1:0]   win_nxt [9];
   logic [9*PIXEL_WIDTH-1:0] win_flat;
   logic                     emit;

   // A restart on the same cycle as a pixel places that pixel at (0,0).
   always_comb begin
      col_cur = frame_restart_i ? '0 : col;
      row_cur = frame_restart_i ? '0 : row;
      lb_a_rd = lb_a[col_cur];
      lb_b_rd = lb_b[col_cur];
      emit    = px_valid_i && (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_nxt[3*r]     = frame_restart_i ? '0 : win_p0[3*r+1];
         win_nxt[3*r + 1] = frame_restart_i ? '0 : win_p0[3*r+2];
         win_nxt[3*r + 2] = '0;
      end
      win_nxt[2] = lb_b_rd;
      win_nxt[5] = lb_a_rd;
      win_nxt[8] = px_i;
      win_flat   = '0;
      for (int k = 0; k < 9; k++)
         win_flat[PIXEL_WIDTH*k +: PIXEL_WIDTH] = win_nxt[k];
   end

   always_ff @(posedge clk_i) begin
      if (px_valid_i) begin
         lb_b[col_cur] <= lb_a_rd;
         lb_a[col_cur] <= px_i;
      end
   end

   // ---- p0: position counters and shift window; p1: registered window output ----
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         col            <= '0;
         row            <= '0;
         for (int k = 0; k < 9; k++) win_p0[k] <= '0;
         window_o       <= '0;
         window_valid_o <= 1'b0;
         center_row_o   <= '0;
         center_col_o   <= '0;
      end else begin
         window_valid_o <= 1'b0;
         if (px_valid_i) begin
            win_p0 <= win_nxt;
            if (col_cur == COL_LAST) begin
               col <= '0;
               row <= (row_cur == ROW_LAST) ? '0 : row_cur + ROW_ONE;
            end else begin
               col <= col_cur + COL_ONE;
               row <= row_cur;
            end
            if (emit) begin
               window_valid_o <= 1'b1;
               window_o       <= win_flat;
               center_row_o   <= row_cur - ROW_ONE;
               center_col_o   <= col_cur - COL_ONE;
            end
         end else if (frame_restart_i) begin
            col <= '0;
            row <= '0;
            for (int k = 0; k < 9; k++) win_p0[k] <= '0;
         end
      end
   end

`ifdef GRAY_WINDOW_FRAME_DONE_EN
   logic last_px;

   assign last_px = px_valid_i && (row_cur == ROW_LAST) && (col_cur == COL_LAST);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         frame_done_o  <= 1'b0;
         frame_count_o <= '0;
      end else begin
         frame_done_o <= last_px;
         if (last_px)
            frame_count_o <= frame_count_o + 8'd1;
      end
   end
`endif

endmodule
